// File: rtl/prog_timer_pkg.sv
// Shared state encoding and mode constants for the programmable timer.
package prog_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every presc+1 clocks while run is high.
module prog_timer_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = run && (cnt == presc);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Programmable one-shot / periodic timer with prescaler, done pulse and sticky irq.
//   state | meaning
//   IDLE  | stopped; count holds its last value
//   RUN   | counting prescaled ticks toward the latched final value
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   final_value,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic               irq
);

    state_t             state;
    logic               mode_q;
    logic [WIDTH-1:0]   final_q;
    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               presc_clear;
    logic               running;

    // Any start or stop restarts the prescale phase from zero.
    assign presc_clear = start | stop;
    assign running     = (state == RUN);
    assign busy        = running;

    prog_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (running),
        .presc (presc_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            mode_q  <= MODE_ONESHOT;
            final_q <= '0;
            presc_q <= '0;
            done    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (irq_clr) begin
                irq <= 1'b0;
            end
            if (stop) begin
                state <= IDLE;
            end else if (start) begin
                mode_q  <= mode;
                final_q <= final_value;
                presc_q <= prescale;
                count   <= '0;
                state   <= RUN;
            end else if (running && tick) begin
                if (count == final_q) begin
                    // Later assignment wins over a coincident irq_clr.
                    done <= 1'b1;
                    irq  <= 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// Randomised and directed bench for prog_timer, checked against an elapsed-time model.
module tb_prog_timer;
    import prog_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, stop, mode, irq_clr;
    logic [15:0] final_value;
    logic [3:0]  prescale;

    logic [15:0] c16;
    logic [7:0]  c8;
    logic        b16, d16, i16, b8, d8, i8;

    int vecs = 0;
    int errs = 0;

    // Reference model: time elapsed since start, count derived arithmetically.
    logic [15:0] m_count;
    logic        m_run, m_done, m_irq, m_mode;
    int          m_final, m_presc, m_t;

    logic [29:0] obs, exp_v;
    assign obs   = {c16, b16, d16, i16, c8, b8, d8, i8};
    assign exp_v = {m_count, m_run, m_done, m_irq, m_count[7:0], m_run, m_done, m_irq};

    always #5 clk = ~clk;

    prog_timer #(.WIDTH(16), .PRESC_W(4)) dut16 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .final_value(final_value), .prescale(prescale), .irq_clr(irq_clr),
        .count(c16), .busy(b16), .done(d16), .irq(i16)
    );

    prog_timer #(.WIDTH(8), .PRESC_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .final_value(final_value[7:0]), .prescale(prescale), .irq_clr(irq_clr),
        .count(c8), .busy(b8), .done(d8), .irq(i8)
    );

    task automatic step();
        int per;
        @(posedge clk);
        if (reset) begin
            m_run = 1'b0; m_mode = 1'b0; m_final = 0; m_presc = 0; m_t = 0;
            m_count = '0; m_done = 1'b0; m_irq = 1'b0;
        end else begin
            m_done = 1'b0;
            if (irq_clr) m_irq = 1'b0;
            if (stop) begin
                m_run = 1'b0;
            end else if (start) begin
                m_mode = mode; m_final = int'(final_value); m_presc = int'(prescale);
                m_t = 0; m_count = '0; m_run = 1'b1;
            end else if (m_run) begin
                m_t++;
                per = (m_final + 1) * (m_presc + 1);
                if (m_t % per == 0) begin
                    m_done = 1'b1; m_irq = 1'b1;
                    if (m_mode == MODE_ONESHOT) begin
                        m_run = 1'b0; m_count = 16'(m_final);
                    end else begin
                        m_count = '0;
                    end
                end else begin
                    m_count = 16'((m_t % per) / (m_presc + 1));
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic launch(input logic md, input int fin, input int ps);
        mode = md; final_value = 16'(fin); prescale = 4'(ps); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; irq_clr = 1'b0;
        mode = 1'b1; final_value = 16'd5; prescale = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (obs !== 30'd0) begin
                errs++; $display("FAIL reset cyc %0d: got %h expected 0", i, obs);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_oneshot();
        int done_at = -1, pulses = 0;
        launch(MODE_ONESHOT, 3, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL oneshot step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16) begin pulses++; done_at = i; end
        end
        vecs++;
        if (done_at !== 4 || pulses !== 1 || c16 !== 16'd3 || i16 !== 1'b1 || b16 !== 1'b0) begin
            errs++;
            $display("FAIL oneshot_timing: done_at=%0d pulses=%0d count=%0d irq=%0b busy=%0b expected 4 1 3 1 0",
                     done_at, pulses, c16, i16, b16);
        end
    endtask

    task automatic test_periodic();
        int pulses = 0, bad_pos = 0;
        launch(MODE_PERIODIC, 2, 1);
        for (int i = 1; i <= 19; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL periodic step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16) begin
                pulses++;
                if (i % 6 != 0) bad_pos++;
            end
        end
        vecs++;
        if (pulses !== 3 || bad_pos !== 0) begin
            errs++; $display("FAIL periodic_interval: pulses=%0d misplaced=%0d expected 3 0", pulses, bad_pos);
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_final_zero();
        int pulses_p = 0, pulses_o = 0;
        launch(MODE_PERIODIC, 0, 3);
        for (int i = 1; i <= 16; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL final0_periodic step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16) pulses_p++;
        end
        stop = 1'b1; step(); stop = 1'b0;
        launch(MODE_ONESHOT, 0, 3);
        for (int i = 1; i <= 16; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL final0_oneshot step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16) pulses_o++;
        end
        vecs++;
        if (pulses_p !== 4 || pulses_o !== 1) begin
            errs++; $display("FAIL final0_pulses: periodic=%0d oneshot=%0d expected 4 1", pulses_p, pulses_o);
        end
    endtask

    task automatic test_stop();
        launch(MODE_ONESHOT, 10, 0);
        for (int i = 0; i < 20 && m_count != 16'd5; i++) step();
        stop = 1'b1; step(); stop = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL stop step %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        vecs++;
        if (c16 !== 16'd5 || b16 !== 1'b0 || d16 !== 1'b0) begin
            errs++; $display("FAIL stop_hold: count=%0d busy=%0b done=%0b expected 5 0 0", c16, b16, d16);
        end
        stop = 1'b1; start = 1'b1; final_value = 16'd3;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        vecs++;
        if (b16 !== 1'b0 || c16 !== 16'd5 || obs !== exp_v) begin
            errs++; $display("FAIL stop_and_start: busy=%0b count=%0d expected 0 5", b16, c16);
        end
    endtask

    task automatic test_restart();
        int done_at = -1;
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        launch(MODE_ONESHOT, 9, 0);
        for (int i = 0; i < 20 && m_count != 16'd7; i++) step();
        launch(MODE_ONESHOT, 9, 0);
        for (int i = 1; i <= 13; i++) begin
            irq_clr = (m_run && m_t == 9);
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL restart step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16 && done_at < 0) done_at = i;
        end
        irq_clr = 1'b0;
        vecs++;
        if (done_at !== 10 || i16 !== 1'b1) begin
            errs++; $display("FAIL restart_done: done_at=%0d irq=%0b expected 10 1", done_at, i16);
        end
        irq_clr = 1'b1; step(); irq_clr = 1'b0;
        vecs++;
        if (i16 !== 1'b0 || i8 !== 1'b0) begin
            errs++; $display("FAIL irq_clear: irq=%0b/%0b expected 0", i16, i8);
        end
    endtask

    task automatic test_reset_midrun();
        int done_at = -1, pulses = 0;
        launch(MODE_PERIODIC, $urandom_range(2, 5), 15);
        for (int i = 0; i < 30; i++) step();
        reset = 1'b1; step();
        vecs++;
        if (obs !== 30'd0) begin
            errs++; $display("FAIL reset_midrun: got %h expected 0", obs);
        end
        reset = 1'b0; step();
        vecs++;
        if (obs !== 30'd0) begin
            errs++; $display("FAIL reset_nodone: got %h expected 0", obs);
        end
        launch(MODE_ONESHOT, 1, 15);
        for (int i = 1; i <= 40; i++) begin
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL post_reset step %0d: got %h expected %h", i, obs, exp_v);
            end
            if (d16) begin pulses++; done_at = i; end
        end
        vecs++;
        if (done_at !== 32 || pulses !== 1) begin
            errs++; $display("FAIL post_reset_timing: done_at=%0d pulses=%0d expected 32 1", done_at, pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 249) == 0);
            start       = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            irq_clr     = ($urandom_range(0, 7) == 0);
            mode        = 1'($urandom_range(0, 1));
            final_value = 16'($urandom_range(0, 7));
            prescale    = 4'($urandom_range(0, 3));
            step();
            vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mode = 1'b0; final_value = '0; prescale = '0;
        m_count = '0; m_run = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_mode = 1'b0;
        m_final = 0; m_presc = 0; m_t = 0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_final_zero();
        test_stop();
        test_restart();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
